// File: rtl/data_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_access_stage : MIPS MEM stage - data RAM, wait states, MEM/WB reg    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module data_access_stage #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        zero,
  input  logic        branch_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  output logic        stall,
  output logic        branch_out,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        misaligned
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0]   mem_q [MEM_DEPTH];
  logic [31:0]   rdata_q;
  logic          valid_q, load_q, uns_q, rw_q, m2r_q, mis_q;
  logic [1:0]    size_q, off_q;
  logic [31:0]   alu_q;
  logic [4:0]    rd_q;

  logic          w_req, w_mis, w_go, w_stall, w_complete;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_data;

  assign w_req = valid_in & (mem_read | mem_write);
  assign w_mis = w_req & (((mem_size == 2'b01) & addr_in[0]) |
                          (mem_size[1] & (addr_in[1:0] != 2'b00)));
  assign w_go  = w_req & ~w_mis;
  assign w_idx = addr_in[AW+1:2];

  generate
    if (WAIT_STATES == 0) begin : g_nowait
      assign w_stall    = 1'b0;
      assign w_complete = w_go;
    end else begin : g_wait
      localparam logic [3:0] WS_RELOAD = 4'(WAIT_STATES - 1);
      typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
      state_e     state_q;
      logic [3:0] cnt_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
        end else begin
          case (state_q)
            ST_IDLE: if (w_go) begin
              state_q <= ST_BUSY;
              cnt_q   <= WS_RELOAD;
            end
            default: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                     else state_q <= ST_IDLE;
          endcase
        end
      end

      assign w_stall    = (state_q == ST_IDLE) ? w_go : (cnt_q != 4'd0);
      assign w_complete = (state_q == ST_BUSY) & (cnt_q == 4'd0) & w_go;
    end
  endgenerate

  // Store data is replicated across lanes; the byte enables pick the target lane(s).
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = write_data;
    case (mem_size)
      2'b00: begin
        w_be    = 4'b0001 << addr_in[1:0];
        w_wdata = {4{write_data[7:0]}};
      end
      2'b01: begin
        w_be    = addr_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_complete & ~rst) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
      rdata_q <= mem_q[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      alu_q   <= 32'd0;
      rd_q    <= 5'd0;
    end else if (w_stall) begin
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      valid_q <= valid_in;
      load_q  <= w_complete & mem_read & ~mem_write;
      uns_q   <= mem_unsigned;
      rw_q    <= reg_write_in & ~w_mis;
      m2r_q   <= mem_to_reg_in;
      mis_q   <= w_mis;
      size_q  <= mem_size;
      off_q   <= addr_in[1:0];
      alu_q   <= addr_in;
      rd_q    <= rd_in;
    end
  end

  assign w_byte = rdata_q[{off_q, 3'b000} +: 8];
  assign w_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    w_data = 32'd0;
    if (load_q) begin
      case (size_q)
        2'b00:   w_data = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        2'b01:   w_data = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        default: w_data = rdata_q;
      endcase
    end
  end

  assign stall          = w_stall;
  assign branch_out     = valid_in & branch_in & zero;
  assign valid_out      = valid_q;
  assign data_out       = w_data;
  assign alu_result_out = alu_q;
  assign rd_out         = rd_q;
  assign reg_write_out  = rw_q;
  assign mem_to_reg_out = m2r_q;
  assign misaligned     = mis_q;
endmodule
`default_nettype wire

// File: tb/tb_data_access_stage.sv
`default_nettype none
// Testbench for data_access_stage: two instances (0 and 3 wait states), byte-level RAM model,
// queue scoreboard popped by a monitor whenever valid_out is seen.
module tb_data_access_stage;
  localparam int DEPTH = 256;
  localparam int NB    = 4 * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, valid_in, mem_read, mem_write, mem_unsigned, zero, branch_in;
  logic        reg_write_in, mem_to_reg_in;
  logic [31:0] addr_in, write_data;
  logic [1:0]  mem_size;
  logic [4:0]  rd_in;
  logic        v0, v1;
  assign v0 = valid_in & ~sel;
  assign v1 = valid_in & sel;

  logic        st0, br0, vo0, rw0, m2r0, mis0, st1, br1, vo1, rw1, m2r1, mis1;
  logic [31:0] do0, alu0, do1, alu1;
  logic [4:0]  rdo0, rdo1;

  data_access_stage #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .valid_in(v0), .addr_in(addr_in), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .zero(zero), .branch_in(branch_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .stall(st0), .branch_out(br0), .valid_out(vo0),
    .data_out(do0), .alu_result_out(alu0), .rd_out(rdo0), .reg_write_out(rw0),
    .mem_to_reg_out(m2r0), .misaligned(mis0));

  data_access_stage #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .valid_in(v1), .addr_in(addr_in), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .zero(zero), .branch_in(branch_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .stall(st1), .branch_out(br1), .valid_out(vo1),
    .data_out(do1), .alu_result_out(alu1), .rd_out(rdo1), .reg_write_out(rw1),
    .mem_to_reg_out(m2r1), .misaligned(mis1));

  typedef struct {
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;

  exp_t       q0[$], q1[$];
  logic [7:0] bm [2][NB];
  int         checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, req);
    end
  endtask

  task automatic mon_cmp(input string tag, input exp_t e, input logic [31:0] d, input logic [31:0] a,
                         input logic [4:0] r, input logic rw, input logic m2r, input logic mis);
    chk({tag, "_data"}, d, e.data);
    chk({tag, "_alu"}, a, e.alu);
    chk({tag, "_rd"}, 32'(r), 32'(e.rd));
    chk({tag, "_regwrite"}, 32'(rw), 32'(e.rw));
    chk({tag, "_memtoreg"}, 32'(m2r), 32'(e.m2r));
    chk({tag, "_misaligned"}, 32'(mis), 32'(e.mis));
  endtask

  // Monitor: pops one expectation per valid_out cycle of each instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (vo0) begin
        if (q0.size() == 0) chk("ws0_unexpected_valid", 32'd1, 32'd0);
        else mon_cmp("ws0", q0.pop_front(), do0, alu0, rdo0, rw0, m2r0, mis0);
      end
      if (vo1) begin
        if (q1.size() == 0) chk("ws3_unexpected_valid", 32'd1, 32'd0);
        else mon_cmp("ws3", q1.pop_front(), do1, alu1, rdo1, rw1, m2r1, mis1);
      end
    end
  end

  function automatic logic cur_stall();
    return sel ? st1 : st0;
  endfunction

  task automatic issue(input logic s, input logic v, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rdi, input logic rw,
                       input logic m2r, input logic br, input logic z);
    int   n, ba, stalls, exp_stalls;
    logic req, mis;
    exp_t e;
    logic [31:0] val;
    @(negedge clk);
    sel = s; valid_in = v; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    addr_in = a; write_data = wd; rd_in = rdi; reg_write_in = rw; mem_to_reg_in = m2r;
    branch_in = br; zero = z;
    #1;
    chk("branch_out", 32'(s ? br1 : br0), 32'(v & br & z));
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    req = v & (rd | wr);
    mis = req & (((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00)));
    exp_stalls = (req && !mis && s) ? 3 : 0;
    stalls = 0;
    while (cur_stall() && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
      chk("valid_during_stall", 32'(s ? vo1 : vo0), 32'd0);
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    ba  = int'(a % NB);
    val = 32'd0;
    if (req && !mis) begin
      if (wr) begin
        for (int i = 0; i < n; i++) bm[s][ba + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) val = val | (32'(bm[s][ba + i]) << (8 * i));
        if (n == 1 && !uns) val = 32'($signed(val[7:0]));
        if (n == 2 && !uns) val = 32'($signed(val[15:0]));
      end
    end
    e.data = val; e.alu = a; e.rd = rdi; e.rw = rw & ~mis; e.m2r = m2r; e.mis = mis;
    if (v) begin
      if (s) q1.push_back(e);
      else q0.push_back(e);
    end
  endtask

  task automatic ld(input logic s, input logic [1:0] sz, input logic uns, input logic [31:0] a);
    issue(s, 1, 1, 0, sz, uns, a, 32'd0, 5'd9, 1, 1, 0, 0);
  endtask

  task automatic st(input logic s, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    issue(s, 1, 0, 1, sz, 0, a, wd, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; valid_in = 0;
    @(negedge clk);
    chk("rst_valid_out", 32'({vo0, vo1}), 32'd0);
    chk("rst_data_out", do0 | do1, 32'd0);
    chk("rst_alu_out", alu0 | alu1, 32'd0);
    chk("rst_misc_out", 32'({rdo0, rdo1, rw0, rw1, m2r0, m2r1, mis0, mis1}), 32'd0);
    q0.delete(); q1.delete();
    rst = 0;
  endtask

  initial begin
    rst = 1; sel = 0; valid_in = 0; mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0;
    addr_in = 0; write_data = 0; rd_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
    branch_in = 0; zero = 0;
    repeat (2) @(negedge clk);
    do_reset();
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++) st(1'(s), 2'd2, 32'(4 * w), $urandom);

    for (int s = 0; s < 2; s++) begin
      st(1'(s), 2'd2, 32'd0, 32'h3);
      st(1'(s), 2'd2, 32'd4, 32'h7);
      ld(1'(s), 2'd2, 0, 32'd0);
      ld(1'(s), 2'd2, 0, 32'd4);
      st(1'(s), 2'd0, 32'd5, 32'h80);
      ld(1'(s), 2'd0, 0, 32'd5);
      ld(1'(s), 2'd0, 1, 32'd5);
      ld(1'(s), 2'd2, 0, 32'd4);
      st(1'(s), 2'd1, 32'd2, 32'hBEEF);
      ld(1'(s), 2'd1, 0, 32'd2);
      ld(1'(s), 2'd1, 1, 32'd2);
      ld(1'(s), 2'd2, 0, 32'd0);
      issue(1'(s), 1, 1, 0, 2'd2, 0, 32'd6, 32'd0, 5'd3, 1, 1, 0, 0);
      st(1'(s), 2'd1, 32'd5, 32'hFFFF);
      ld(1'(s), 2'd2, 0, 32'd4);
      issue(1'(s), 1, 0, 0, 2'd0, 0, 32'h1234, 32'd0, 5'd4, 1, 0, 1, 0);
      issue(1'(s), 1, 0, 0, 2'd0, 0, 32'h1234, 32'd0, 5'd4, 1, 0, 1, 1);
      issue(1'(s), 1, 1, 1, 2'd2, 0, 32'd8, 32'hCAFE0001, 5'd5, 1, 0, 0, 0);
      ld(1'(s), 2'd2, 0, 32'(NB + 4));
      issue(1'(s), 0, 1, 0, 2'd2, 0, 32'd0, 32'd0, 5'd6, 1, 1, 0, 0);
    end

    // Reset partway through a waited store must abort it.
    @(negedge clk);
    sel = 1; valid_in = 1; mem_read = 0; mem_write = 1; mem_size = 2'd2; addr_in = 32'd12;
    write_data = 32'hDEADBEEF; branch_in = 0;
    repeat (2) @(negedge clk);
    rst = 1; valid_in = 0;
    @(negedge clk);
    rst = 0;
    q0.delete(); q1.delete();
    ld(1, 2'd2, 0, 32'd12);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] r;
      int kind;
      r    = $urandom;
      kind = $urandom_range(0, 9);
      issue(1'($urandom_range(0, 1)), kind != 9, (kind <= 3) || (kind == 7),
            (kind >= 4) && (kind <= 7), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            {r[31:10], 4'b0000, r[5:0]}, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    valid_in = 0;
    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
